// File: rtl/flop_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flop_cmp_arbiter
// Description : Round-robin arbiter sharing one flop_greaterthan comparator
//               among N_REQ requesters. Optional equality result enabled by
//               the FLOP_CMP_EQUAL_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_cmp_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] first_in,
    input  logic [N_REQ*WIDTH-1:0] second_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic                   result_greater,
    output logic [WIDTH-1:0]       cmp_first,
    output logic [WIDTH-1:0]       cmp_second,
    input  logic                   cmp_greater,
    output logic                   result_equal
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_last_grant;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_done;
    logic               r_result_greater;
    logic [WIDTH-1:0]   r_cmp_first;
    logic [WIDTH-1:0]   r_cmp_second;

    state_t             w_state_nxt;
    logic [GW-1:0]      w_last_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic [N_REQ-1:0]   w_done_nxt;
    logic               w_gt_nxt;
    logic [WIDTH-1:0]   w_first_nxt;
    logic [WIDTH-1:0]   w_second_nxt;
    logic               w_found;
    logic [GW-1:0]      w_grant;
    logic [GW:0]        w_idx;

    // Search upward from the requester after the last grant, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(N_REQ)) begin
                w_idx = w_idx - (GW+1)'(N_REQ);
            end
            if (!w_found && req[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last_grant;
        w_ack_nxt    = '0;
        w_done_nxt   = '0;
        w_gt_nxt     = r_result_greater;
        w_first_nxt  = r_cmp_first;
        w_second_nxt = r_cmp_second;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_first_nxt  = first_in[w_grant*WIDTH +: WIDTH];
                    w_second_nxt = second_in[w_grant*WIDTH +: WIDTH];
                    w_ack_nxt    = N_REQ'(1) << w_grant;
                    w_last_nxt   = w_grant;
                    w_state_nxt  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_gt_nxt    = cmp_greater;
                w_done_nxt  = N_REQ'(1) << r_last_grant;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_last_grant     <= GW'(N_REQ - 1);
            r_ack            <= '0;
            r_done           <= '0;
            r_result_greater <= 1'b0;
            r_cmp_first      <= '0;
            r_cmp_second     <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_last_grant     <= w_last_nxt;
            r_ack            <= w_ack_nxt;
            r_done           <= w_done_nxt;
            r_result_greater <= w_gt_nxt;
            r_cmp_first      <= w_first_nxt;
            r_cmp_second     <= w_second_nxt;
        end
    end

`ifdef FLOP_CMP_EQUAL_EN
    logic r_result_equal;

    // Sampled alongside result_greater so requesters get >= from one compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result_equal <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            r_result_equal <= (r_cmp_first == r_cmp_second);
        end
    end

    assign result_equal = r_result_equal;
`else
    assign result_equal = 1'b0;
`endif

    assign ack            = r_ack;
    assign done           = r_done;
    assign result_greater = r_result_greater;
    assign cmp_first      = r_cmp_first;
    assign cmp_second     = r_cmp_second;

endmodule
`default_nettype wire

// File: tb/tb_flop_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flop_cmp_arbiter
// Description : Self-checking bench for flop_cmp_arbiter with a sign-magnitude
//               comparator model on the cmp_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_cmp_arbiter;

    localparam int N = 4;
    localparam int W = 13;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] first_in;
    logic [N*W-1:0] second_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic           result_greater;
    logic [W-1:0]   cmp_first;
    logic [W-1:0]   cmp_second;
    logic           cmp_greater;
    logic           result_equal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Sign-magnitude ordering; +0 and -0 compare equal.
    function automatic logic fgt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a[W-1] != b[W-1])
            return !a[W-1] && ((a[W-2:0] != 0) || (b[W-2:0] != 0));
        else if (!a[W-1])
            return a[W-2:0] > b[W-2:0];
        else
            return a[W-2:0] < b[W-2:0];
    endfunction

    assign cmp_greater = fgt(cmp_first, cmp_second);

    flop_cmp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .first_in       (first_in),
        .second_in      (second_in),
        .ack            (ack),
        .done           (done),
        .result_greater (result_greater),
        .cmp_first      (cmp_first),
        .cmp_second     (cmp_second),
        .cmp_greater    (cmp_greater),
        .result_equal   (result_equal)
    );

    // Reference model: cycles remaining in the current transaction plus the
    // round-robin pointer; grants are picked by a modulo search.
    int           m_busy;
    int           m_last;
    logic [N-1:0] exp_ack, exp_done;
    logic         exp_gt, exp_eq;
    logic [W-1:0] exp_cf, exp_cs;

    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_last <= N - 1;
            exp_ack <= '0; exp_done <= '0; exp_gt <= 1'b0; exp_eq <= 1'b0;
            exp_cf <= '0; exp_cs <= '0;
        end else if (m_busy == 0) begin
            exp_done <= '0;
            if (req != 0) begin
                exp_ack <= N'(1) << pick(m_last, req);
                m_last  <= pick(m_last, req);
                exp_cf  <= first_in[pick(m_last, req)*W +: W];
                exp_cs  <= second_in[pick(m_last, req)*W +: W];
                m_busy  <= 2;
            end else begin
                exp_ack <= '0;
            end
        end else if (m_busy == 2) begin
            exp_ack  <= '0;
            exp_done <= N'(1) << m_last;
            exp_gt   <= fgt(exp_cf, exp_cs);
`ifdef FLOP_CMP_EQUAL_EN
            exp_eq   <= (exp_cf == exp_cs);
`else
            exp_eq   <= 1'b0;
`endif
            m_busy   <= 1;
        end else begin
            exp_done <= '0;
            m_busy   <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("done", 64'(done), 64'(exp_done));
        chk("result_greater", 64'(result_greater), 64'(exp_gt));
        chk("result_equal", 64'(result_equal), 64'(exp_eq));
        chk("cmp_first", 64'(cmp_first), 64'(exp_cf));
        chk("cmp_second", 64'(cmp_second), 64'(exp_cs));
        chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
        chk("ack_done_excl", 64'((|ack) && (|done)), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_op(input int i, input logic [W-1:0] f, input logic [W-1:0] s);
        first_in[i*W +: W]  = f;
        second_in[i*W +: W] = s;
    endtask

    function automatic int ack_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    initial begin
        int order[$];
        int exp_order[5] = '{1, 2, 3, 0, 1};
        logic [W-1:0] f, s;
        bit seen;

        reset_n = 1'b0; req = '0; first_in = '0; second_in = '0;
        #100;
        check_all();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) tick();

        // Single requester
        set_op(2, 13'h1802, 13'h1801);
        req = 4'b0100;
        tick();
        chk("single_ack", 64'(ack), 64'h4);
        chk("single_cf", 64'(cmp_first), 64'h1802);
        chk("single_cs", 64'(cmp_second), 64'h1801);
        req = '0;
        tick();
        chk("single_done", 64'(done), 64'h4);
        chk("single_gt", 64'(result_greater), 64'(fgt(13'h1802, 13'h1801)));
        tick();

        // Equal operands
        set_op(0, 13'h1801, 13'h1801);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("equal_done", 64'(done), 64'h1);
        chk("equal_gt", 64'(result_greater), 64'd0);
`ifdef FLOP_CMP_EQUAL_EN
        chk("equal_eq", 64'(result_equal), 64'd1);
`else
        chk("equal_eq", 64'(result_equal), 64'd0);
`endif
        tick();

        // Contention: last grant was 0, so the rotation starts at 1
        for (int i = 0; i < N; i++) set_op(i, W'(13'h0100 + 3*i), W'(13'h0102 + i));
        req = 4'b1111;
        repeat (15) begin
            tick();
            if (|ack) order.push_back(ack_index(ack));
        end
        req = '0;
        chk("contention_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("contention_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        repeat (3) tick();

        // Reset in the cycle after ack[1]
        req = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (ack[1]) seen = 1'b1;
        end
        chk("rst_ack1_seen", 64'(seen), 64'd1);
        reset_n = 1'b0; req = '0;
        repeat (3) begin
            tick();
            chk("rst_no_done", 64'(done), 64'd0);
        end
        reset_n = 1'b1; req = 4'b0011;
        tick();
        chk("rst_first_grant", 64'(ack), 64'h1);
        req = '0;
        repeat (3) tick();

        // Sweep requester 0, alternately bumping first and second
        f = 13'h1801; s = 13'h1801;
        for (int g = 0; g < 20; g++) begin
            if (g % 2 == 0) f = f + 1'b1; else s = s + 1'b1;
            set_op(0, f, s);
            req = 4'b0001;
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                tick();
                if (ack[0]) seen = 1'b1;
            end
            chk("sweep_ack_seen", 64'(seen), 64'd1);
            req = '0;
            tick();
            chk("sweep_gt", 64'(result_greater), 64'(fgt(f, s)));
            tick();
        end

        // Randomized requests and operands
        repeat (300) begin
            req       = N'($urandom_range(0, (1 << N) - 1));
            first_in  = (N*W)'({$urandom(), $urandom()});
            second_in = (N*W)'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) second_in[W-1:0] = first_in[W-1:0];
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
